// File: rtl/ecc_result_collector_if.sv
// Result capture and host read-out signals of the ECC result collector.
// The master side is the environment (ECC top + host); the slave side is the collector.
interface ecc_result_collector_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  operation_done;
    logic [1:0]            num_of_errors;
    logic [1:0]            ctrl_mode;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_errors;
    logic                  out_ready;

    modport master (
        output data_out, operation_done, num_of_errors, ctrl_mode, out_ready,
        input  out_valid, out_data, out_errors
    );

    modport slave (
        input  data_out, operation_done, num_of_errors, ctrl_mode, out_ready,
        output out_valid, out_data, out_errors
    );
endinterface

// File: rtl/ecc_result_collector.sv
// Captures ECC results into a circular FIFO for a valid/ready reader and keeps
// saturating corrected/detected error statistics plus a sticky overflow flag.
module ecc_result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ecc_result_collector_if.slave      bus,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    input  logic                       clr_stats,
    output logic [CNT_WIDTH-1:0]       single_err_cnt,
    output logic [CNT_WIDTH-1:0]       double_err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [AW-1:0]        PTR_ONE  = 1;
    localparam logic [AW:0]          FILL_ONE = 1;
    localparam logic [AW:0]          FILL_MAX = DEPTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    localparam logic [1:0] MODE_ENC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_FULL = 2'b10;
    localparam logic [1:0] ERR_SINGLE = 2'b01;
    localparam logic [1:0] ERR_DOUBLE = 2'b10;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill_q;
    logic [AW:0]   fill_d;

    logic       push;
    logic       pop;
    logic       full;
    logic       accept;
    logic       drop;
    logic       is_decode;
    logic [1:0] entry_errs;
    logic       inc_single;
    logic       inc_double;

    assign push   = bus.operation_done;
    assign full   = (fill_q == FILL_MAX);
    assign pop    = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a push when the reader frees the head in the same cycle.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign is_decode  = (bus.ctrl_mode == MODE_DEC) || (bus.ctrl_mode == MODE_FULL);
    assign entry_errs = (bus.ctrl_mode == MODE_ENC) ? 2'b00 : bus.num_of_errors;
    assign inc_single = push && is_decode && (bus.num_of_errors == ERR_SINGLE)
                        && (single_err_cnt != '1);
    assign inc_double = push && is_decode && (bus.num_of_errors == ERR_DOUBLE)
                        && (double_err_cnt != '1);

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fill_d = fill_q;
        case ({accept, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // NOTE: the storage array has no reset; its contents are don't-care until written, and
    // out_valid gating below keeps stale words off the outputs.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {bus.data_out, entry_errs};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
            fill_q <= fill_d;
        end
    end

    // Clear wins over a same-cycle increment or drop; that event is simply not recorded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow       <= 1'b0;
            single_err_cnt <= '0;
            double_err_cnt <= '0;
        end else if (clr_stats) begin
            overflow       <= 1'b0;
            single_err_cnt <= '0;
            double_err_cnt <= '0;
        end else begin
            if (drop)       overflow       <= 1'b1;
            if (inc_single) single_err_cnt <= single_err_cnt + CNT_ONE;
            if (inc_double) double_err_cnt <= double_err_cnt + CNT_ONE;
        end
    end

    assign fill_level     = fill_q;
    assign bus.out_valid  = (fill_q != '0);
    assign bus.out_data   = bus.out_valid ? mem[rd_ptr][EW-1:2] : '0;
    assign bus.out_errors = bus.out_valid ? mem[rd_ptr][1:0]    : 2'b00;
endmodule

// File: doc/ecc_result_collector.md
# ecc_result_collector

Downstream consumer of the ECC encoder/decoder top. Captures each completed result (`data_out` and `num_of_errors`, qualified by the one-cycle `operation_done` pulse) into a small FIFO and presents entries to a host-side reader over a valid/ready handshake. Maintains saturating statistics of corrected and detected errors for decode operations. Flags results lost to a full buffer.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: width of a captured result word.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `CNT_WIDTH`, default 16: width of each statistics counter.

**Ports**
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `data_out`, input, `DATA_WIDTH`: result word from the ECC top.
- `operation_done`, input, 1: one-cycle pulse qualifying `data_out` and `num_of_errors`.
- `num_of_errors`, input, 2: encoding is `00` none, `01` single (corrected), `10` double (detected), `11` reserved.
- `ctrl_mode`, input, 2: the CTRL mode of the current operation. `00` encoder only, `01` decoder only, `10` full channel.
- `out_valid`, output, 1: head entry is available.
- `out_data`, output, `DATA_WIDTH`: head entry data.
- `out_errors`, output, 2: head entry `num_of_errors`. Stored as `00` when the capture was in encoder-only mode.
- `out_ready`, input, 1: reader accepts the head entry.
- `fill_level`, output, `$clog2(DEPTH)+1`: number of occupied entries.
- `overflow`, output, 1: sticky flag; at least one result was dropped.
- `clr_stats`, input, 1: synchronous clear of `overflow` and both counters.
- `single_err_cnt`, output, `CNT_WIDTH`: count of decode results with `01`.
- `double_err_cnt`, output, `CNT_WIDTH`: count of decode results with `10`.

## Operation

**Push**
- A push occurs on any cycle with `operation_done` = 1.
- The stored entry is `{data_out, errs}`, where `errs` = `num_of_errors` if `ctrl_mode` ≠ `00`, else `00`.

**Pop**
- A pop occurs on any cycle with `out_valid` && `out_ready`.
- `out_ready` while empty has no effect.

**Storage and flags**
- Storage is a circular buffer with read/write pointers of `$clog2(DEPTH)` bits that wrap at `DEPTH`.
- `fill_level` distinguishes full from empty.
- `out_valid` = (`fill_level` ≠ 0).
- `out_data` and `out_errors` are read from the head and are stable while `out_valid` && !`out_ready`.

**Full-buffer behaviour**
- Push while full without a simultaneous pop: the entry is dropped, `overflow` sets, and pointers are unchanged.
- Push while full with a simultaneous pop: both are performed. The push is accepted, no overflow, and `fill_level` stays at `DEPTH`.
- Push and pop in the same cycle at any other level: both are performed and `fill_level` is unchanged.

**Statistics**
- Counters update on every push, including dropped pushes.
- They count only when `ctrl_mode` ∈ {`01`, `10`}.
- `01` increments `single_err_cnt`; `10` increments `double_err_cnt`; `00` and `11` increment neither.
- Counters saturate at all-ones; no wrap.
- `clr_stats` zeroes both counters and `overflow` on the next edge.
- `clr_stats` has priority over a same-cycle increment or overflow; that event is not counted. FIFO contents are unaffected by `clr_stats`.

## Timing

**Reset (while `rst` = 0)**
- `out_valid` = 0, `fill_level` = 0, `overflow` = 0, both counters = 0, pointers = 0.
- `out_data` and `out_errors` = 0.
- Storage contents are don't-care.
- Reset mid-operation discards all entries immediately (asynchronously). A pending `operation_done` in that cycle is lost.

**Latency**
- A push into an empty FIFO at edge N gives `out_valid` = 1 with the entry visible after edge N.
- There is no combinational bypass from `data_out` to `out_data`.

**Other edge behaviour**
- A pop at edge N presents the next entry, or drops `out_valid` if it was the last, after edge N.
- `fill_level`, `overflow` and the counters are registered and update at the same edge as the triggering event.
- Back-to-back `operation_done` pulses on consecutive cycles are each captured (full throughput, one push per cycle).

## Test plan

- **Reset:** hold `rst` = 0 with random inputs → all outputs 0. Release, then idle 5 cycles → outputs stay 0.
- **Single capture:** `ctrl_mode` = `01`, `data_out` = `32'hDEAD_BEEF`, `num_of_errors` = `01`, one `operation_done` pulse.
  - Next cycle: `out_valid` = 1, `out_data` = `DEADBEEF`, `out_errors` = `01`, `single_err_cnt` = 1.
  - `out_ready` = 1 for one cycle → `out_valid` = 0, `fill_level` = 0.
- **Fill and overflow:** with `out_ready` = 0, push 9 words 1..9 in consecutive cycles (DEPTH = 8) → `fill_level` = 8 and `overflow` = 1. Then draining reads 1..8 in order, and 9 is absent.
- **Full with simultaneous push/pop:** at full, pulse `operation_done` with `out_ready` = 1 → `overflow` stays 0 and `fill_level` stays 8. Draining yields the original order followed by the new word.
- **Encoder-only capture:** `ctrl_mode` = `00`, `num_of_errors` = `10` → `out_errors` = `00` and `double_err_cnt` unchanged. Repeat with `ctrl_mode` = `10` → `double_err_cnt` increments by 1.
- **Saturation and clear:** with `CNT_WIDTH` = 4, 20 single-error decodes → `single_err_cnt` = 15. Assert `clr_stats` in the same cycle as an error → both counters = 0 and `overflow` = 0 next cycle; FIFO contents are intact.
